// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-channel add/subtract stream engine:
// lane mode encodings, saturation bounds and a queue-entry shape.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CHANNELS   = 2;

  // One queued result vector at the default widths.
  typedef struct packed {
    logic [DEF_CHANNELS*DEF_DATA_WIDTH-1:0] result;
    logic [DEF_CHANNELS-1:0]                overflow;
  } entry_t;

  // Largest positive two's complement value of the given width.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's complement value of the given width.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/addsub_lane.sv
// One combinational lane: signed A+B or A-B with overflow detection and
// optional clamping to the representable range.
module addsub_lane
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic                         mode,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         ovf
);

  localparam logic signed [63:0]           MAX64 = sat_max(DATA_WIDTH);
  localparam logic signed [63:0]           MIN64 = sat_min(DATA_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] MAXV  = MAX64[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] MINV  = MIN64[DATA_WIDTH-1:0];

  // Clamp a one-bit-wider sum: the extra top bit gives the true sign.
  function automatic logic signed [DATA_WIDTH-1:0] clamp(input logic signed [DATA_WIDTH:0] s);
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return s[DATA_WIDTH] ? MINV : MAXV;
    return s[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH:0] a_x;
  logic signed [DATA_WIDTH:0] b_x;
  logic signed [DATA_WIDTH:0] s_x;

  // Extended-precision add/sub, overflow when the two top bits disagree.
  always_comb begin
    a_x = {a[DATA_WIDTH-1], a};
    b_x = {b[DATA_WIDTH-1], b};
    s_x = (mode == MODE_SUB) ? (a_x - b_x) : (a_x + b_x);
    ovf = s_x[DATA_WIDTH] ^ s_x[DATA_WIDTH-1];
    y   = SATURATE ? clamp(s_x) : s_x[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/addsub_stream.sv
// Multi-channel add/subtract engine between an upstream FWFT FIFO and a
// downstream FIFO, with a small circular result queue in between.
module addsub_stream
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int OUT_DEPTH  = 2,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_empty,
  output logic                           in_rd_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] op1,
  input  logic [CHANNELS*DATA_WIDTH-1:0] op2,
  input  logic [CHANNELS-1:0]            mode,
  input  logic                           out_full,
  output logic                           out_wr_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] result,
  output logic [CHANNELS-1:0]            overflow,
  output logic [31:0]                    ops_done
);

  localparam int VW   = CHANNELS * DATA_WIDTH;
  localparam int PW   = $clog2(OUT_DEPTH);
  localparam int CNTW = PW + 1;

  logic [VW-1:0]       lane_y;
  logic [CHANNELS-1:0] lane_ovf;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    addsub_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
    ) u_lane (
      .a    (op1[g*DATA_WIDTH +: DATA_WIDTH]),
      .b    (op2[g*DATA_WIDTH +: DATA_WIDTH]),
      .mode (mode[g]),
      .y    (lane_y[g*DATA_WIDTH +: DATA_WIDTH]),
      .ovf  (lane_ovf[g])
    );
  end

  logic [VW-1:0]       q_data_q [OUT_DEPTH];
  logic [VW-1:0]       q_data_d [OUT_DEPTH];
  logic [CHANNELS-1:0] q_ovf_q  [OUT_DEPTH];
  logic [CHANNELS-1:0] q_ovf_d  [OUT_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [31:0]         ops_done_q, ops_done_d;
  // Last popped head, shown while the queue is empty so result stays put.
  logic [VW-1:0]       hold_data_q, hold_data_d;
  logic [CHANNELS-1:0] hold_ovf_q, hold_ovf_d;
  logic                push, pop;

  // Handshake decode and next-state for queue, pointers and counter.
  always_comb begin
    push        = !reset && !in_empty && (count_q < CNTW'(OUT_DEPTH));
    pop         = !reset && (count_q != '0) && !out_full;
    q_data_d    = q_data_q;
    q_ovf_d     = q_ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ops_done_d  = ops_done_q;
    hold_data_d = hold_data_q;
    hold_ovf_d  = hold_ovf_q;
    if (push) begin
      q_data_d[wr_ptr_q] = lane_y;
      q_ovf_d[wr_ptr_q]  = lane_ovf;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      hold_data_d = q_data_q[rd_ptr_q];
      hold_ovf_d  = q_ovf_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ops_done_d  = ops_done_q + 32'd1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state and held head: cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ops_done_q  <= '0;
      hold_data_q <= '0;
      hold_ovf_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ops_done_q  <= ops_done_d;
      hold_data_q <= hold_data_d;
      hold_ovf_q  <= hold_ovf_d;
    end
  end

  // Queue storage: never visible unless count says the slot is live.
  always_ff @(posedge clock) begin
    q_data_q <= q_data_d;
    q_ovf_q  <= q_ovf_d;
  end

  assign in_rd_en  = push;
  assign out_wr_en = pop;
  assign result    = (count_q != '0) ? q_data_q[rd_ptr_q] : hold_data_q;
  assign overflow  = (count_q != '0) ? q_ovf_q[rd_ptr_q]  : hold_ovf_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_addsub_stream.sv
// Bench for addsub_stream: a saturating and a wrapping instance share all
// inputs and are checked against an integer-arithmetic reference queue.
module tb_addsub_stream;

  localparam int W     = 8;
  localparam int CH    = 2;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_empty = 1'b1;
  logic          out_full = 1'b0;
  logic [CH*W-1:0] op1 = '0;
  logic [CH*W-1:0] op2 = '0;
  logic [CH-1:0]   mode = '0;

  logic            rd_s, wr_s, rd_w, wr_w;
  logic [CH*W-1:0] res_s, res_w;
  logic [CH-1:0]   ovf_s, ovf_w;
  logic [31:0]     ops_s, ops_w;

  addsub_stream #(.DATA_WIDTH(W), .CHANNELS(CH), .OUT_DEPTH(DEPTH), .SATURATE(1'b1)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(rd_s),
    .op1(op1), .op2(op2), .mode(mode), .out_full(out_full), .out_wr_en(wr_s),
    .result(res_s), .overflow(ovf_s), .ops_done(ops_s));

  addsub_stream #(.DATA_WIDTH(W), .CHANNELS(CH), .OUT_DEPTH(DEPTH), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(rd_w),
    .op1(op1), .op2(op2), .mode(mode), .out_full(out_full), .out_wr_en(wr_w),
    .result(res_w), .overflow(ovf_w), .ops_done(ops_w));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [CH*W-1:0] sat;
    logic [CH*W-1:0] wrap;
    logic [CH-1:0]   ovf;
  } exp_t;

  exp_t        scoreboard[$];
  int unsigned ops_model = 0;
  int          total = 0;
  int          bad = 0;

  // Reference: exact integer result, then clamp or keep low byte.
  function automatic exp_t model(input logic [CH*W-1:0] a, input logic [CH*W-1:0] b,
                                 input logic [CH-1:0] m);
    exp_t e;
    int sa, sbv, s;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      sa  = int'($signed(a[i*W +: W]));
      sbv = int'($signed(b[i*W +: W]));
      s   = m[i] ? (sa - sbv) : (sa + sbv);
      e.ovf[i] = (s > 127) || (s < -128);
      if (s > 127)       e.sat[i*W +: W] = 8'h7f;
      else if (s < -128) e.sat[i*W +: W] = 8'h80;
      else               e.sat[i*W +: W] = s[7:0];
      e.wrap[i*W +: W] = s[7:0];
    end
    return e;
  endfunction

  // Advance one clock, scoring handshakes and popped data at the negedge.
  task automatic cycle_and_score();
    exp_t e;
    logic exp_rd, exp_wr;
    @(negedge clock);
    exp_rd = !in_empty && (scoreboard.size() < DEPTH);
    exp_wr = (scoreboard.size() > 0) && !out_full;
    total++;
    if ({rd_s, rd_w} !== {2{exp_rd}}) begin
      bad++; $display("FAIL in_rd_en got=%b/%b want=%b", rd_s, rd_w, exp_rd);
    end
    total++;
    if ({wr_s, wr_w} !== {2{exp_wr}}) begin
      bad++; $display("FAIL out_wr_en got=%b/%b want=%b", wr_s, wr_w, exp_wr);
    end
    total++;
    if (ops_s !== ops_model || ops_w !== ops_model) begin
      bad++; $display("FAIL ops_done got=%0d/%0d want=%0d", ops_s, ops_w, ops_model);
    end
    if (exp_wr) begin
      e = scoreboard.pop_front();
      ops_model++;
      total++;
      if (res_s !== e.sat || ovf_s !== e.ovf) begin
        bad++; $display("FAIL sat_result got=%h/%b want=%h/%b", res_s, ovf_s, e.sat, e.ovf);
      end
      total++;
      if (res_w !== e.wrap || ovf_w !== e.ovf) begin
        bad++; $display("FAIL wrap_result got=%h/%b want=%h/%b", res_w, ovf_w, e.wrap, e.ovf);
      end
    end
    if (exp_rd) scoreboard.push_back(model(op1, op2, mode));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    in_empty = 1'b0;
    out_full = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (rd_s !== 1'b0 || wr_s !== 1'b0 || rd_w !== 1'b0 || wr_w !== 1'b0) begin
      bad++; $display("FAIL reset_handshake got=%b%b%b%b want=0000", rd_s, wr_s, rd_w, wr_w);
    end
    total++;
    if (res_s !== '0 || ovf_s !== '0 || res_w !== '0 || ovf_w !== '0) begin
      bad++; $display("FAIL reset_result got=%h/%b want=0/0", res_s, ovf_s);
    end
    total++;
    if (ops_s !== 32'd0 || ops_w !== 32'd0) begin
      bad++; $display("FAIL reset_ops got=%0d want=0", ops_s);
    end
    in_empty = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    scoreboard.delete();
    ops_model = 0;
  endtask

  task automatic test_single();
    in_empty = 1'b0;
    op1  = {8'd5, 8'd5};
    op2  = {8'd3, 8'd3};
    mode = 2'b01;
    cycle_and_score();
    in_empty = 1'b1;
    #1;
    total++;
    if (wr_s !== 1'b1 || res_s !== {8'd8, 8'd2} || ovf_s !== 2'b00) begin
      bad++; $display("FAIL single_head got=%b/%h/%b want=1/0802/00", wr_s, res_s, ovf_s);
    end
    cycle_and_score();
    total++;
    if (ops_s !== 32'd1) begin
      bad++; $display("FAIL single_ops got=%0d want=1", ops_s);
    end
    total++;
    if (wr_s !== 1'b0 || res_s !== {8'd8, 8'd2}) begin
      bad++; $display("FAIL empty_hold got=%b/%h want=0/0802", wr_s, res_s);
    end
  endtask

  task automatic test_saturation();
    in_empty = 1'b0;
    op1  = {8'h80, 8'h7f};
    op2  = {8'h01, 8'h01};
    mode = 2'b10;
    cycle_and_score();
    in_empty = 1'b1;
    #1;
    total++;
    if (res_s !== {8'h80, 8'h7f} || ovf_s !== 2'b11) begin
      bad++; $display("FAIL saturate got=%h/%b want=807f/11", res_s, ovf_s);
    end
    total++;
    if (res_w !== {8'h7f, 8'h80} || ovf_w !== 2'b11) begin
      bad++; $display("FAIL wrap got=%h/%b want=7f80/11", res_w, ovf_w);
    end
    cycle_and_score();
  endtask

  task automatic test_backpressure();
    logic [CH*W-1:0] va[4];
    logic [CH*W-1:0] vb[4];
    int idx, base;
    logic popped;
    for (int i = 0; i < 4; i++) begin
      va[i] = CH*W'($urandom);
      vb[i] = CH*W'($urandom);
    end
    base = int'(ops_model);
    idx = 0;
    out_full = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_empty = (idx >= 4);
      if (idx < 4) begin
        op1 = va[idx]; op2 = vb[idx]; mode = 2'(idx);
      end
      #1;
      popped = rd_s && !in_empty;
      cycle_and_score();
      if (popped) idx++;
    end
    total++;
    if (idx !== 2) begin
      bad++; $display("FAIL bp_stall got=%0d want=2", idx);
    end
    out_full = 1'b0;
    for (int c = 0; c < 20 && idx < 4 + 0 || (c < 20 && scoreboard.size() > 0); c++) begin
      in_empty = (idx >= 4);
      if (idx < 4) begin
        op1 = va[idx]; op2 = vb[idx]; mode = 2'(idx);
      end
      #1;
      popped = rd_s && !in_empty;
      cycle_and_score();
      if (popped) idx++;
    end
    in_empty = 1'b1;
    total++;
    if (ops_s - 32'(base) !== 32'd4) begin
      bad++; $display("FAIL bp_count got=%0d want=4", ops_s - 32'(base));
    end
  endtask

  task automatic test_streaming();
    int pushes;
    pushes = 0;
    out_full = 1'b0;
    for (int c = 0; c < 100; c++) begin
      in_empty = 1'b0;
      op1  = {8'(c), 8'(c + 1)};
      op2  = {8'(3 * c), 8'(c ^ 8'h55)};
      mode = 2'(c);
      #1;
      if (c >= 1 && wr_s) pushes++;
      cycle_and_score();
    end
    in_empty = 1'b1;
    total++;
    if (pushes !== 99) begin
      bad++; $display("FAIL stream_rate got=%0d want=99", pushes);
    end
    for (int c = 0; c < 3; c++) cycle_and_score();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      in_empty = ($urandom_range(0, 2) == 0);
      out_full = ($urandom_range(0, 2) == 0);
      op1  = CH*W'($urandom);
      op2  = CH*W'($urandom);
      mode = CH'($urandom);
      cycle_and_score();
    end
    in_empty = 1'b1;
    out_full = 1'b0;
    for (int c = 0; c < 4; c++) cycle_and_score();
    total++;
    if (scoreboard.size() != 0) begin
      bad++; $display("FAIL random_drain got=%0d want=0", scoreboard.size());
    end
  endtask

  task automatic test_reset_mid();
    out_full = 1'b1;
    in_empty = 1'b0;
    for (int c = 0; c < 3; c++) begin
      op1 = CH*W'($urandom); op2 = CH*W'($urandom); mode = CH'($urandom);
      cycle_and_score();
    end
    in_empty = 1'b1;
    out_full = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (wr_s !== 1'b0 || wr_w !== 1'b0 || ops_s !== 32'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%0d want=0/0", wr_s, ops_s);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    scoreboard.delete();
    ops_model = 0;
    for (int c = 0; c < 3; c++) cycle_and_score();
    total++;
    if (ops_s !== 32'd0) begin
      bad++; $display("FAIL mid_reset_ops got=%0d want=0", ops_s);
    end
    in_empty = 1'b0;
    op1 = {8'd10, 8'd20}; op2 = {8'd1, 8'd2}; mode = 2'b00;
    cycle_and_score();
    in_empty = 1'b1;
    cycle_and_score();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_stream.md
Name: addsub_stream

Overview:
Multi-channel signed add/subtract engine with per-channel mode select and optional saturation. It replaces the single-channel subtractor in the datapath.
- Pulls operand vectors from an upstream first-word-fall-through (FWFT) FIFO.
- Buffers results in a small internal circular queue.
- Pushes results to a downstream FIFO.
- Handshakes only through FIFO-style empty/rd_en and full/wr_en signals.

Parameters:
DATA_WIDTH, 32, bits per channel operand/result (two's complement)
CHANNELS, 2, independent lanes processed in lockstep
OUT_DEPTH, 2, result queue entries (power of two, >=2)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^DATA_WIDTH

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_empty  in  1  upstream FIFO empty
in_rd_en  out  1  pop upstream FIFO this cycle
op1  in  CHANNELS*DATA_WIDTH  operand A, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
op2  in  CHANNELS*DATA_WIDTH  operand B, same packing
mode  in  CHANNELS  per lane: 0 = A+B, 1 = A-B; sampled with operands
out_full  in  1  downstream FIFO full
out_wr_en  out  1  push result this cycle
result  out  CHANNELS*DATA_WIDTH  queue head data, same packing
overflow  out  CHANNELS  per-lane overflow flag travelling with result
ops_done  out  32  count of result vectors pushed; wraps at 2^32

Behaviour:
- Reset, asynchronous, applies immediately:
  - Queue count, wr_ptr and rd_ptr go to 0; ops_done goes to 0.
  - result and overflow go to 0; in_rd_en and out_wr_en go to 0.
  - A reset mid-operation discards all queued entries. No partial push occurs.
- Input side:
  - in_rd_en = !in_empty && (count < OUT_DEPTH). Combinational, no dependence on out_full.
  - When in_rd_en=1, op1/op2/mode are valid in the same cycle (FWFT).
  - Each lane is computed combinationally and written to queue[wr_ptr] at the clock edge; wr_ptr increments and wraps at OUT_DEPTH.
- Lane arithmetic:
  - Sign-extend both operands to DATA_WIDTH+1 and compute A+B or A-B.
  - Overflow = the two top bits of the extended result differ.
  - SATURATE=1: positive overflow gives 2^(DATA_WIDTH-1)-1; negative overflow gives -2^(DATA_WIDTH-1).
  - SATURATE=0: keep the low DATA_WIDTH bits.
  - The overflow flag is reported in both modes.
- Output side:
  - out_wr_en = (count > 0) && !out_full. Combinational.
  - result/overflow are driven from queue[rd_ptr].
  - On out_wr_en, rd_ptr increments (wraps) and ops_done increments.
  - result must not change while count>0 and no pop occurs.
- Latency: 1 cycle. An operand popped in cycle N is at the head and pushable in cycle N+1. No combinational path from in_empty to out_wr_en.
- Throughput: 1 vector/cycle sustained while out_full=0.
- Simultaneous pop and push in one cycle: count unchanged, both pointers advance. This is legal even when count=OUT_DEPTH? No: when full, in_rd_en=0 by rule, so the queue only drains that cycle.
- Empty queue: out_wr_en=0, result holds the last head value.
- Full queue: in_rd_en=0 until a push to the downstream FIFO frees an entry. The freed slot is used the following cycle; there is no same-cycle bypass.
- out_full asserted indefinitely: queue fills to OUT_DEPTH, then input stalls. No data loss, no duplication.
- Count width: $clog2(OUT_DEPTH)+1.

Decomposition:
- Package addsub_pkg:
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - Function sat_max(width) and function sat_min(width).
  - Queue entry struct { result, overflow } helper for the default widths.
- Sub-module addsub_lane: one lane, combinational.
  - Parameters: DATA_WIDTH, SATURATE.
  - Ports: a, b, mode, y, ovf.
  - Instantiated CHANNELS times by generate.
- The top level holds the queue, pointers, count and counter.

Test Plan:
1. Reset then single op, DATA_WIDTH=8, CHANNELS=2: lane0 5-3 sub, lane1 5+3 add.
   -> next cycle out_wr_en=1, result lanes {8, 2} (lane1, lane0), overflow=0, ops_done=1 after push.
2. Saturation, SATURATE=1, W=8: lane0 127+1 add, lane1 -128-1 sub.
   -> results 127 and -128, overflow=2'b11.
   Same stimulus with SATURATE=0 -> -128 and 127, overflow=2'b11.
3. Backpressure, OUT_DEPTH=2: out_full=1, feed 4 vectors.
   -> in_rd_en pops exactly 2 then stays 0.
   Release out_full -> 4 pushes in order, no duplicates, ops_done=4.
4. Streaming: in_empty=0 for 100 cycles, out_full=0, sequential operands.
   -> 1 push/cycle after the first cycle; outputs match the golden model in order.
5. Random toggling of in_empty/out_full over 10k cycles.
   -> scoreboard matches in order; count never exceeds OUT_DEPTH.
6. Assert reset while the queue holds 2 entries.
   -> out_wr_en=0 immediately, ops_done=0, nothing pushed until new input arrives.
